// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider with glitch-free ratio changes and clean stop.
// Optional period counter enabled by defining CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl #(
   parameter int CNT_W = 8,
   parameter int H_RST = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             run_i,
   input  logic             div_req_i,
   input  logic [CNT_W-1:0] div_val_i,
   output logic             div_ack_o,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             busy_o,
   output logic [1:0]       state_o,
   output logic [15:0]      period_cnt_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2, STOP = 2'd3} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt, h_q, pend_q, div_clamp;
   logic             clk_out_q, tick_q, ack_q, busy_q;
   logic             counting, hit, fall, rise, accept;

   always_comb begin
      cnt_nxt   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      hit       = (cnt_nxt == h_q);
      cnt_d     = hit ? '0 : cnt_nxt;
      // STOP keeps counting only to finish a high phase; a low phase may be cut short
      counting  = (state_q == RUN) || (state_q == PEND) || ((state_q == STOP) && clk_out_q);
      fall      = counting && hit && clk_out_q;
      rise      = counting && hit && !clk_out_q;
      accept    = div_req_i && !busy_q && !ack_q;
      div_clamp = (div_val_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : div_val_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         h_q       <= CNT_W'(H_RST);
         pend_q    <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tick_q <= rise;
         ack_q  <= 1'b0;
         if (counting) begin
            cnt_q <= cnt_d;
            if (hit) clk_out_q <= !clk_out_q;
         end
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               clk_out_q <= 1'b0;
               if (accept) begin
                  h_q   <= div_clamp;
                  ack_q <= 1'b1;
               end else if (run_i && !div_req_i) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  pend_q <= div_clamp;
                  busy_q <= 1'b1;
               end
               if (!run_i)      state_q <= STOP;
               else if (accept) state_q <= PEND;
            end
            PEND: begin
               if (!run_i) begin
                  state_q <= STOP;
               end else if (fall) begin
                  // new ratio starts exactly at the period boundary
                  h_q     <= pend_q;
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            STOP: begin
               if (!clk_out_q) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  if (busy_q) begin
                     h_q    <= pend_q;
                     ack_q  <= 1'b1;
                     busy_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign div_ack_o = ack_q;
   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;
   assign busy_o    = busy_q;
   assign state_o   = state_q;

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] pcnt_q;
   always_ff @(posedge clk_i) begin
      if (reset_i)   pcnt_q <= '0;
      else if (fall) pcnt_q <= pcnt_q + 16'd1;
   end
   assign period_cnt_o = pcnt_q;
`else
   assign period_cnt_o = '0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed + randomized bench for clk_div_ctrl; expected waveforms derived arithmetically
// from the half-period H (level = (k/H)%2 cycles after the counting origin).
module tb_clk_div_ctrl;

   logic        clk = 1'b0;
   logic        reset, run, div_req;
   logic [7:0]  div_val;
   logic        div_ack, clk_out, tick, busy;
   logic [1:0]  state;
   logic [15:0] period_cnt;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int fail_cnt = 0;

   clk_div_ctrl #(.CNT_W(8), .H_RST(2)) dut (
      .clk_i(clk), .reset_i(reset), .run_i(run), .div_req_i(div_req), .div_val_i(div_val),
      .div_ack_o(div_ack), .clk_out_o(clk_out), .tick_o(tick), .busy_o(busy),
      .state_o(state), .period_cnt_o(period_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // k counts edges after the counting origin (RUN entry or a ratio switch)
   task automatic wave(input int h, input int n, input string tag);
      int  bad_clk, bad_tick;
      bit  lvl, tk;
      bad_clk  = 0;
      bad_tick = 0;
      for (int k = 1; k <= n; k++) begin
         step();
         lvl = ((k / h) % 2) == 1;
         tk  = (k % (2 * h)) == h;
         if (clk_out !== lvl) bad_clk++;
         if (tick !== tk)     bad_tick++;
      end
      check({tag, "_clk_errs"}, bad_clk, 0);
      check({tag, "_tick_errs"}, bad_tick, 0);
      check({tag, "_state_run"}, state, 1);
   endtask

   task automatic req_idle(input int v, input string tag);
      div_req = 1'b1;
      div_val = 8'(v);
      step();
      div_req = 1'b0;
      check({tag, "_ack"}, div_ack, 1);
      check({tag, "_idle"}, state, 0);
      step();
      check({tag, "_ack_gone"}, div_ack, 0);
   endtask

   task automatic start_run(input string tag);
      run = 1'b1;
      step();
      check({tag, "_enter_run"}, state, 1);
   endtask

   task automatic stop_seq(input int h, input int kprev, input bit exp_pend, input string tag);
      int s, kf, exp_steps, steps;
      bit lvl;
      run = 1'b0;
      step();
      s = kprev + 1;
      check({tag, "_stop_state"}, state, 3);
      check({tag, "_stop_busy"}, busy, exp_pend);
      lvl       = ((s / h) % 2) == 1;
      kf        = (s / (2 * h) + 1) * 2 * h;
      exp_steps = lvl ? (kf - s + 1) : 1;
      steps     = 0;
      while (state !== 2'd0 && steps < 600) begin
         step();
         steps++;
      end
      check({tag, "_stop_len"}, steps, exp_steps);
      check({tag, "_idle_clk"}, clk_out, 0);
      check({tag, "_idle_ack"}, div_ack, exp_pend);
      check({tag, "_idle_busy"}, busy, 0);
      step();
      check({tag, "_post_ack"}, div_ack, 0);
   endtask

   task automatic req_run(input int h, input int n, input int v, input string tag);
      int s, kf, steps;
      div_req = 1'b1;
      div_val = 8'(v);
      step();
      div_req = 1'b0;
      s = n + 1;
      check({tag, "_pend"}, state, 2);
      check({tag, "_busy"}, busy, 1);
      kf    = (s / (2 * h) + 1) * 2 * h;
      steps = 0;
      while (div_ack !== 1'b1 && steps < 600) begin
         step();
         steps++;
      end
      check({tag, "_ack_at_fall"}, steps, kf - s);
      check({tag, "_back_run"}, state, 1);
      check({tag, "_busy_clr"}, busy, 0);
      check({tag, "_low_at_ack"}, clk_out, 0);
   endtask

   initial begin
      int v, v2, n, n2, h, h2;
      reset = 1'b1; run = 1'b0; div_req = 1'b0; div_val = '0;
      step();
      step();
      check("rst_state", state, 0);
      check("rst_clk", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_ack", div_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_pcnt", period_cnt, 0);

      // default divide-by-4 straight out of reset
      reset = 1'b0;
      start_run("div4");
      wave(2, 16, "div4");
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      check("div4_pcnt", period_cnt, 4);
`else
      check("div4_pcnt", period_cnt, 0);
`endif
      stop_seq(2, 16, 0, "div4");

      req_idle(5, "h5");
      start_run("h5");
      wave(5, 25, "h5");
      stop_seq(5, 25, 0, "h5");

      // request held through the ack cycle is ignored there
      div_req = 1'b1; div_val = 8'd2;
      step();
      check("hold_ack1", div_ack, 1);
      step();
      check("hold_ack2", div_ack, 0);
      check("hold_idle", state, 0);
      div_req = 1'b0;
      step();

      // ratio change mid high phase, applied at the next fall
      start_run("chg");
      wave(2, 6, "chg_a");
      req_run(2, 6, 3, "chg");
      wave(3, 12, "chg_b");
      stop_seq(3, 12, 0, "chg");

      // stop one cycle into a high phase: high phase still completes
      req_idle(4, "h4");
      start_run("h4");
      wave(4, 4, "h4");
      stop_seq(4, 4, 0, "h4");

      req_idle(0, "h0");
      start_run("h0");
      wave(1, 10, "h0");
      stop_seq(1, 10, 0, "h0");

      // pending change survives a stop and is applied on IDLE entry
      req_idle(3, "sp");
      start_run("sp");
      wave(3, 4, "sp");
      div_req = 1'b1; div_val = 8'd2;
      step();
      div_req = 1'b0;
      check("sp_pend", state, 2);
      stop_seq(3, 5, 1, "sp");
      start_run("sp2");
      wave(2, 8, "sp2");
      stop_seq(2, 8, 0, "sp2");

      // reset while pending drops the change
      req_idle(2, "rp");
      start_run("rp");
      wave(2, 2, "rp");
      div_req = 1'b1; div_val = 8'd6;
      step();
      check("rp_pend", state, 2);
      div_req = 1'b0; reset = 1'b1; run = 1'b0;
      step();
      check("rp_state", state, 0);
      check("rp_busy", busy, 0);
      check("rp_ack", div_ack, 0);
      check("rp_clk", clk_out, 0);
      reset = 1'b0;
      step();
      check("rp_noack", div_ack, 0);
      check("rp_busy2", busy, 0);
      start_run("rp2");
      wave(2, 8, "rp2");
      stop_seq(2, 8, 0, "rp2");

      for (int it = 0; it < 8; it++) begin
         v = int'($urandom_range(0, 7));
         h = clamp(v);
         n = int'($urandom_range(1, 20));
         req_idle(v, "rnd");
         start_run("rnd");
         wave(h, n, "rnd_a");
         if ($urandom_range(0, 1) == 1) begin
            v2 = int'($urandom_range(0, 7));
            h2 = clamp(v2);
            n2 = int'($urandom_range(1, 15));
            req_run(h, n, v2, "rnd");
            wave(h2, n2, "rnd_b");
            stop_seq(h2, n2, 0, "rnd_b");
         end else begin
            stop_seq(h, n, 0, "rnd_a");
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: CNT_W, 8, width of the half-period count and the divide-value port.
REQ-002 Parameter: H_RST, 2, half-period count loaded at reset (divide-by-4).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; 1 = divider running, 0 = request stop.
REQ-006 div_req  input  1  ratio-change request; held with div_val stable until div_ack.
REQ-007 div_val  input  CNT_W  requested half-period count H, in clk cycles.
REQ-008 div_ack  output  1  one-cycle pulse: the requested H is now in effect.
REQ-009 clk_out  output  1  registered divided clock, period 2*H clk cycles, 50% duty.
REQ-010 tick  output  1  one-cycle pulse during the first clk cycle in which clk_out is high.
REQ-011 busy  output  1  high while an accepted ratio change is pending.
REQ-012 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PEND, 3 STOP.
REQ-013 period_cnt  output  16  count of completed clk_out periods (see Configuration).

Function
REQ-014 Internal counter cnt (CNT_W bits) SHALL use cnt_nxt = cnt+1: if cnt_nxt == H, then cnt <= 0 and clk_out toggles; otherwise cnt <= cnt_nxt.
REQ-015 div_val == 0 SHALL be clamped to H = 1; all other values SHALL be used unchanged, with no wrap-around.
REQ-016 A fall event SHALL be the edge at which clk_out toggles 1->0; it is the only period boundary.
REQ-017 IDLE: cnt = 0 and clk_out = 0 held; IDLE->RUN when run = 1 and div_req = 0; the first clk_out rise occurs after H cycles in RUN.
REQ-018 IDLE with div_req = 1: H <= clamp(div_val) at the next edge, div_ack is high the following cycle, and the FSM stays IDLE; div_req takes priority over run.
REQ-019 RUN with div_req = 1: div_val is captured into a pending register, busy = 1, RUN->PEND.
REQ-020 PEND: at the next fall event, H <= pending and cnt <= 0; div_ack is high the following cycle; PEND->RUN.
REQ-021 RUN or PEND with run = 0 -> STOP; any pending change is retained.
REQ-022 STOP: if clk_out = 1, counting continues to the fall event; if clk_out = 0, the FSM SHALL move to IDLE at the next edge with cnt <= 0. No high phase is ever truncated.
REQ-023 On entry to IDLE from STOP, a pending change SHALL be applied and div_ack pulsed one cycle later.
REQ-024 div_req SHALL be ignored while busy = 1 and in the cycle div_ack is high; a div_req still high after that cycle starts a new transaction.
REQ-025 The new H SHALL never be applied mid-period; each half-period uses one H value.
REQ-026 run = 1 in STOP SHALL NOT abort the stop; the FSM returns to IDLE first, then restarts.

Reset
REQ-027 reset = 1 SHALL force: state = IDLE, cnt = 0, H = H_RST, pending = 0, clk_out = 0, tick = 0, div_ack = 0, busy = 0, period_cnt = 0, within one edge.
REQ-028 Reset mid-transaction SHALL drop the pending change with no div_ack; the requester re-issues it.

Configuration
REQ-029 Macro CLK_DIV_CTRL_PERIOD_CNT_EN defined: period_cnt increments by 1 on every fall event, wraps 0xFFFF -> 0, and is cleared only by reset.
REQ-030 Macro CLK_DIV_CTRL_PERIOD_CNT_EN undefined: the period_cnt port remains present and is tied to 0; no counter logic is synthesized.

Verification
REQ-031 Reset released, run = 1, no requests -> clk_out 2 high / 2 low repeating; tick every 4 cycles.
REQ-032 IDLE, div_req with div_val = 5 -> div_ack one cycle later; run = 1 -> clk_out period 10.
REQ-033 RUN at H = 2, req div_val = 3 during a high phase -> busy = 1; current period completes at H = 2; div_ack after the fall; next period is 6.
REQ-034 run = 0 one cycle into a high phase at H = 4 -> high phase lasts the full 4 cycles, then IDLE with clk_out = 0.
REQ-035 div_val = 0 -> H = 1, clk_out toggles every cycle; with the macro defined, period_cnt wraps after 65536 periods.
REQ-036 reset asserted while PEND -> IDLE, H = 2, no div_ack, busy = 0 next cycle.
